// File: rtl/io_uart_pkg.sv
// Shared constants and types for the memory-mapped UART.
package io_uart_pkg;

  // Word offsets inside the 16-byte register window
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_RXDATA  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_BAUDDIV = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  // Smallest usable divisor: RX needs div/2 >= 2 to land mid-bit
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Receive path: 2-flop synchronizer, falling-edge start detect, 8N1 sampler.
// Emits single-cycle byte_done / frame_err pulses; data is valid with byte_done.
module uart_rx_fsm
  import io_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic [15:0] div,
  output logic        byte_done,
  output logic [7:0]  data,
  output logic        frame_err
);

  logic        sync1, sync2, prev;
  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n, div_l, div_l_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  sh, sh_n;

  // Synchronize the async line; prev holds last synced value for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_l   <= MIN_DIV;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_l   <= div_l_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
    end
  end

  // Next-state: half-bit wait in START to hit bit centres, then full-bit steps
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_l_n   = div_l;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (prev && !sync2) begin
          state_n = START;
          div_l_n = div;
          cnt_n   = {1'b0, div[15:1]} - 16'd1;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (sync2) begin
            state_n = IDLE;              // line back high: glitch
          end else begin
            state_n   = DATA;
            cnt_n     = div_l - 16'd1;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_n  = {sync2, sh[7:1]};      // LSB arrives first
          cnt_n = div_l - 16'd1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (sync2) byte_done = 1'b1;
          else       frame_err = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign data = sh;

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: bus decode, register file, transmit FSM.
// Read data is registered and forced to 0 when unselected for OR-muxing.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0100,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic [3:0]  io_be,
  output logic [31:0] io_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  logic        sel, wr;
  logic [1:0]  off;
  logic [15:0] baud_div, baud_wr_val;
  logic        rx_valid, rx_overrun, frame_err;
  logic [7:0]  rx_byte;
  logic        rx_done, rx_ferr;
  logic [7:0]  rx_data;
  logic        clr_wr, tx_start, tx_busy;
  logic [31:0] rdata_n;
  logic        unused;

  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        txd_n;

  assign sel      = (io_addr[31:4] == BASE_ADDR[31:4]);
  assign off      = io_addr[3:2];
  assign wr       = sel && io_we;
  assign clr_wr   = wr && (off == OFF_STATUS) && io_be[0];
  assign tx_busy  = (tx_state != IDLE);
  assign tx_start = wr && (off == OFF_TXDATA) && io_be[0] && !tx_busy;
  assign unused   = ^{io_wdata[31:16], io_be[3:2]};

  assign baud_wr_val = {io_be[1] ? io_wdata[15:8] : baud_div[15:8],
                        io_be[0] ? io_wdata[7:0]  : baud_div[7:0]};

  uart_rx_fsm u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (uart_rxd),
    .div       (baud_div),
    .byte_done (rx_done),
    .data      (rx_data),
    .frame_err (rx_ferr)
  );

  // Baud divisor with per-byte write and lower clamp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_div <= CLKS_PER_BIT;
    else if (wr && (off == OFF_BAUDDIV) && (|io_be[1:0])) baud_div <= clamp_div(baud_wr_val);
  end

  // Receive flags: hardware set beats a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      rx_valid   <= rx_done | (rx_valid & ~(clr_wr & io_wdata[ST_RX_VALID]));
      rx_overrun <= (rx_done & rx_valid) | (rx_overrun & ~(clr_wr & io_wdata[ST_RX_OVERRUN]));
      frame_err  <= rx_ferr | (frame_err & ~(clr_wr & io_wdata[ST_FRAME_ERR]));
      if (rx_done) rx_byte <= rx_data;
    end
  end

  // Read mux, zero when not selected
  always_comb begin
    rdata_n = '0;
    if (sel) begin
      case (off)
        OFF_RXDATA:  rdata_n = {24'b0, rx_byte};
        OFF_STATUS:  rdata_n = {28'b0, frame_err, rx_overrun, rx_valid, tx_busy};
        OFF_BAUDDIV: rdata_n = {16'b0, baud_div};
        default:     rdata_n = '0;
      endcase
    end
  end

  // Registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) io_rdata <= '0;
    else       io_rdata <= rdata_n;
  end

  // TX state register; txd is registered so the line never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_div   <= CLKS_PER_BIT;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      uart_txd <= txd_n;
    end
  end

  // TX next-state: divisor latched at frame start, one div period per slot
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    case (tx_state)
      IDLE: begin
        if (tx_start) begin
          tx_state_n = START;
          tx_div_n   = baud_div;
          tx_cnt_n   = baud_div - 16'd1;
          tx_sh_n    = io_wdata[7:0];
        end
      end
      START: begin
        if (tx_cnt == '0) begin
          tx_state_n = DATA;
          tx_cnt_n   = tx_div - 16'd1;
          tx_bit_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = tx_div - 16'd1;
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt == '0) tx_state_n = IDLE;
        else              tx_cnt_n   = tx_cnt - 16'd1;
      end
      default: tx_state_n = IDLE;
    endcase
    case (tx_state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
- Memory-mapped UART responder on the CPU's word-addressed I/O bus (io_addr/io_wdata/io_we/io_be/io_rdata), sitting beside the existing LED/pushbutton I/O block.
- Gives software a byte transmitter on ESP32_UART1_TXD and a byte receiver on ESP32_UART1_RXD.
- Format is 8N1, LSB first, with a programmable baud divisor.
- Read data is registered (1-cycle latency, same as data RAM) and returns 0 when not selected, so the top level can OR it with other responders.

Parameters:
- BASE_ADDR, 32'h8000_0100, byte base of the 16-byte register window; must be 16-byte aligned.
- CLKS_PER_BIT, 868, reset value of BAUDDIV (100 MHz / 115200).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_addr  in  30  word address [31:2] from MEM stage
- io_wdata  in  32  write data
- io_we  in  1  write strobe, one cycle per store
- io_be  in  4  byte enables
- io_rdata  out  32  registered read data
- uart_txd  out  1  serial transmit line, idle high
- uart_rxd  in  1  serial receive line, asynchronous

Behaviour:
- Select: sel = (io_addr[31:4] == BASE_ADDR[31:4]). Word offset = io_addr[3:2].
- Register map:
  - 0 TXDATA: write with be[0] loads io_wdata[7:0] and starts a frame only if TX is idle; write while busy is dropped. Reads 0.
  - 1 RXDATA: reads {24'b0, rx_byte}. Reading has no side effect.
  - 2 STATUS: read bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 frame_err, other bits 0. Write with be[0]: bits[3:1] are W1C; bit0 ignored.
  - 3 BAUDDIV: R/W [15:0], per-byte enables apply, upper bits read 0. Stored values <4 clamp to 4.
- io_rdata: registered. Address in cycle N gives data in cycle N+1. Output is 0 in N+1 if sel was 0 in N.
- Reset (asynchronous):
  - uart_txd=1, io_rdata=0, BAUDDIV=CLKS_PER_BIT.
  - All status flags 0, both FSMs IDLE, rx_byte=0.
  - A frame in progress is abandoned; the line goes high immediately.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Accepted write in cycle N: uart_txd=0 and tx_busy=1 from N+1.
  - Each state/bit lasts div cycles, where div is BAUDDIV latched at frame start; mid-frame BAUDDIV writes affect the next frame only.
  - DATA shifts 8 bits LSB first (3-bit bit counter). STOP drives 1.
  - Total frame is 10*div cycles. tx_busy clears the cycle after STOP ends, and a new write is accepted from that cycle.
- RX input: uart_rxd passes through a 2-flop synchronizer, reset value 1.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a synced 1->0 transition enters START, with div latched.
  - START: after div/2 cycles (integer floor) re-sample. If the line is 1, it was a glitch: return to IDLE with no flags set. Otherwise go to DATA.
  - DATA: sample every div cycles, 8 bits LSB first.
  - STOP: sample after div cycles.
    - Stop=1: rx_byte<=data. If rx_valid was already 1, set rx_overrun (new byte overwrites). Then set rx_valid.
    - Stop=0: set frame_err; data discarded; rx_valid/rx_byte unchanged.
  - Return to IDLE right after the stop sample; the next falling edge is detected from then on.
- Simultaneous events:
  - W1C on rx_valid in the same cycle a byte completes: set wins (rx_valid stays 1).
  - The same applies to the overrun and frame_err flags.
- Counters: 16-bit down-counters; the bit boundary is at count==0, then the counter reloads div-1.

Decomposition:
- Package io_uart_pkg holds:
  - register offset localparams (OFF_TXDATA=0, OFF_RXDATA=1, OFF_STATUS=2, OFF_BAUDDIV=3)
  - STATUS bit index constants
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}, shared by TX and RX
  - MIN_DIV=4
- One sub-module, uart_rx_fsm: synchronizer plus receive FSM. It outputs a 1-cycle byte_done pulse with data, and a 1-cycle frame_err pulse.
- TX FSM, register file and bus decode stay in io_uart.

Test Plan:
- Reset, then read BAUDDIV -> 868 next cycle. Read STATUS -> 0. uart_txd=1. Read of an unselected address -> io_rdata=0.
- BAUDDIV=4, write TXDATA=0x55 in cycle N:
  - txd=0 for N+1..N+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - tx_busy=1 for exactly 40 cycles.
  - A second write at N+10 is dropped: no second frame.
- Drive uart_rxd with 0xA3 at div=8 (8N1) -> rx_valid=1, RXDATA=0xA3, overrun=0. Write STATUS=0x2 -> rx_valid=0.
- Two back-to-back frames 0x11, 0x22 with no clear in between -> RXDATA=0x22, rx_valid=1, rx_overrun=1.
- Other receive faults:
  - 2-cycle low glitch at div=8 -> no flags set.
  - Frame 0x5A with stop bit driven 0 -> frame_err=1, rx_valid=0.
- Assert reset mid-TX (bit 3) and mid-RX -> txd=1 immediately, all flags 0. A subsequent frame works normally.
